// File: rtl/avmm_m0_reg_responder.sv
// Avalon-MM register responder for the CPU subsystem's 8-bit external master
// port. Provides NREGS read/write config registers, NREGS read-only status
// registers and a saturating access-error counter at 0xFF. Wait states and
// pipelined read latency are fixed by parameters.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   avs_address          byte address
//   avs_read/avs_write   transfer requests
//   avs_writedata        write data
//   avs_waitrequest      stall; a transfer is accepted when req=1 and this is 0
//   avs_readdata         read data, qualified by avs_readdatavalid
//   avs_readdatavalid    read response strobe, RD_LATENCY cycles after accept
//   cfg_regs_o           flat config registers, reg i = bits [8i+7:8i]
//   cfg_wr_strb_o        one-cycle pulse on bit i after reg i is written
//   stat_i               flat status inputs, sampled at read acceptance

module avmm_m0_reg_responder #(
  parameter int         NREGS       = 32,
  parameter int         WAIT_STATES = 1,
  parameter int         RD_LATENCY  = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [7:0]         avs_writedata,
  output logic               avs_waitrequest,
  output logic [7:0]         avs_readdata,
  output logic               avs_readdatavalid,
  output logic [NREGS*8-1:0] cfg_regs_o,
  output logic [NREGS-1:0]   cfg_wr_strb_o,
  input  logic [NREGS*8-1:0] stat_i
);

  localparam logic [1:0] WS = 2'(WAIT_STATES);

  logic [1:0]         r_wcnt;
  logic [NREGS*8-1:0] r_cfg;
  logic [NREGS-1:0]   r_strb;
  logic [7:0]         r_err_cnt;
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [7:0]         r_pipe_data [RD_LATENCY];

  logic               w_req;
  logic               w_accept;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_both;
  logic [NREGS-1:0]   w_cfg_sel;
  logic               w_cfg_hit;
  logic               w_stat_hit;
  logic               w_err_hit;
  logic [7:0]         w_rd_data;
  logic               w_err_inc;
  logic               w_err_clr;
  logic [7:0]         w_err_base;
  logic [7:0]         w_err_next;

  assign w_req           = avs_read | avs_write;
  assign avs_waitrequest = reset | (w_req & (r_wcnt != WS));
  assign w_accept        = w_req & ~avs_waitrequest;
  assign w_both          = avs_read & avs_write;
  // read+write together is handled as a write only
  assign w_wr_acc        = w_accept & avs_write;
  assign w_rd_acc        = w_accept & avs_read & ~avs_write;

  // Address decode and read mux; the err_cnt value is the pre-update one.
  always_comb begin
    w_cfg_sel  = '0;
    w_stat_hit = 1'b0;
    w_rd_data  = 8'h00;
    w_err_hit  = (avs_address == 8'hFF);
    for (int i = 0; i < NREGS; i++) begin
      if (avs_address == 8'(i)) begin
        w_cfg_sel[i] = 1'b1;
        w_rd_data    = r_cfg[8*i +: 8];
      end
      if (avs_address == 8'(128 + i)) begin
        w_stat_hit = 1'b1;
        w_rd_data  = stat_i[8*i +: 8];
      end
    end
    if (w_err_hit) begin
      w_rd_data = r_err_cnt;
    end
  end

  assign w_cfg_hit = |w_cfg_sel;

  // At most one increment per accepted access, whatever the combination of
  // error causes. A write to 0xFF clears first, so a read+write to 0xFF
  // leaves the counter at 1.
  assign w_err_inc  = w_accept & (w_both |
                      (w_wr_acc & ~w_cfg_hit & ~w_err_hit) |
                      (w_rd_acc & ~w_cfg_hit & ~w_stat_hit & ~w_err_hit));
  assign w_err_clr  = w_wr_acc & w_err_hit;
  assign w_err_base = w_err_clr ? 8'h00 : r_err_cnt;
  assign w_err_next = (w_err_inc && (w_err_base != 8'hFF)) ? w_err_base + 8'd1 : w_err_base;

  // Wait counter: counts held-but-unaccepted cycles, restarts on accept or drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt <= 2'd0;
    end else if (!w_req || w_accept) begin
      r_wcnt <= 2'd0;
    end else begin
      r_wcnt <= r_wcnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg     <= {NREGS{RESET_VAL}};
      r_strb    <= '0;
      r_err_cnt <= 8'h00;
    end else begin
      r_strb    <= w_wr_acc ? w_cfg_sel : '0;
      r_err_cnt <= w_err_next;
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_acc && w_cfg_sel[i]) begin
          r_cfg[8*i +: 8] <= avs_writedata;
        end
      end
    end
  end

  // Read response pipeline; stage RD_LATENCY-1 drives the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_data[i] <= 8'h00;
      end
    end else begin
      r_pipe_vld[0]  <= w_rd_acc;
      r_pipe_data[0] <= w_rd_acc ? w_rd_data : 8'h00;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  assign avs_readdatavalid = r_pipe_vld[RD_LATENCY-1];
  assign avs_readdata      = r_pipe_data[RD_LATENCY-1];
  assign cfg_regs_o        = r_cfg;
  assign cfg_wr_strb_o     = r_strb;

endmodule

// File: tb/tb_avmm_m0_reg_responder.sv
// Bench for avmm_m0_reg_responder. Three instances with different wait-state
// and read-latency settings share the clock and reset. A reference model
// (register arrays plus a queue of timed expected events) predicts read data,
// response timing, strobes and err_cnt from the address-map rules.

module tb_avmm_m0_reg_responder;

  localparam int WS_OF [3] = '{1, 0, 3};
  localparam int RL_OF [3] = '{2, 2, 3};

  logic clk = 1'b0;
  logic reset;
  logic [2:0][7:0]   addr;
  logic [2:0][7:0]   wdata;
  logic [2:0]        rd;
  logic [2:0]        wr;
  logic [2:0][255:0] stat;
  wire  [2:0]        wreq;
  wire  [2:0]        rvalid;
  wire  [2:0][7:0]   rdata;
  wire  [2:0][255:0] cfg;
  wire  [2:0][31:0]  strb;

  always #5 clk = ~clk;

  avmm_m0_reg_responder #(.NREGS(32), .WAIT_STATES(1), .RD_LATENCY(2), .RESET_VAL(8'h00)) u_dut0 (
    .clk(clk), .reset(reset), .avs_address(addr[0]), .avs_read(rd[0]), .avs_write(wr[0]),
    .avs_writedata(wdata[0]), .avs_waitrequest(wreq[0]), .avs_readdata(rdata[0]),
    .avs_readdatavalid(rvalid[0]), .cfg_regs_o(cfg[0]), .cfg_wr_strb_o(strb[0]), .stat_i(stat[0]));

  avmm_m0_reg_responder #(.NREGS(32), .WAIT_STATES(0), .RD_LATENCY(2), .RESET_VAL(8'h00)) u_dut1 (
    .clk(clk), .reset(reset), .avs_address(addr[1]), .avs_read(rd[1]), .avs_write(wr[1]),
    .avs_writedata(wdata[1]), .avs_waitrequest(wreq[1]), .avs_readdata(rdata[1]),
    .avs_readdatavalid(rvalid[1]), .cfg_regs_o(cfg[1]), .cfg_wr_strb_o(strb[1]), .stat_i(stat[1]));

  avmm_m0_reg_responder #(.NREGS(32), .WAIT_STATES(3), .RD_LATENCY(3), .RESET_VAL(8'h00)) u_dut2 (
    .clk(clk), .reset(reset), .avs_address(addr[2]), .avs_read(rd[2]), .avs_write(wr[2]),
    .avs_writedata(wdata[2]), .avs_waitrequest(wreq[2]), .avs_readdata(rdata[2]),
    .avs_readdatavalid(rvalid[2]), .cfg_regs_o(cfg[2]), .cfg_wr_strb_o(strb[2]), .stat_i(stat[2]));

  typedef struct {
    int          d;
    int          cyc;
    logic [31:0] val;
    bit          is_rd;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mcfg [3][32];
  logic [7:0] merr [3];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      merr[d] = 8'h00;
      for (int i = 0; i < 32; i++) mcfg[d][i] = 8'h00;
    end
    evq.delete();
  endtask

  task automatic check_cfg(input int d);
    logic [255:0] flat;
    for (int i = 0; i < 32; i++) flat[8*i +: 8] = mcfg[d][i];
    check_val($sformatf("d%0d cfg", d), cfg[d], flat);
  endtask

  function automatic bit is_mapped(input logic [7:0] a);
    return (a < 8'd32) || (a >= 8'h80 && a < 8'hA0) || (a == 8'hFF);
  endfunction

  // Applies the effects of one accepted access to the model.
  task automatic model_accept(input int d, input logic [7:0] a, input bit r, input bit w,
                              input logic [7:0] wd, input logic [255:0] st);
    logic [7:0]  rdv;
    logic [31:0] one;
    bit          bad;
    one = 32'd1;
    bad = 1'b0;
    if (a < 8'd32)                     rdv = mcfg[d][a];
    else if (a >= 8'h80 && a < 8'hA0)  rdv = st[8*(a-8'h80) +: 8];
    else if (a == 8'hFF)               rdv = merr[d];
    else                               rdv = 8'h00;
    if (w) begin
      if (a < 8'd32) begin
        mcfg[d][a] = wd;
        evq.push_back('{d: d, cyc: cyc + 1, val: one << a, is_rd: 1'b0});
      end else if (a == 8'hFF) begin
        merr[d] = 8'h00;
      end else begin
        bad = 1'b1;
      end
    end else if (r) begin
      if (!is_mapped(a)) bad = 1'b1;
      evq.push_back('{d: d, cyc: cyc + RL_OF[d], val: {24'h0, rdv}, is_rd: 1'b1});
    end
    if (r && w) bad = 1'b1;
    if (bad && merr[d] != 8'hFF) merr[d] = merr[d] + 8'd1;
  endtask

  // Monitor: every cycle, compare response and strobe outputs against events due now.
  always @(negedge clk) begin
    logic        exp_v;
    logic [7:0]  exp_d;
    logic [31:0] exp_s;
    for (int d = 0; d < 3; d++) begin
      exp_v = 1'b0;
      exp_d = 8'h00;
      exp_s = 32'h0;
      for (int k = evq.size() - 1; k >= 0; k--) begin
        if (evq[k].d == d && evq[k].cyc == cyc) begin
          if (evq[k].is_rd) begin
            exp_v = 1'b1;
            exp_d = evq[k].val[7:0];
          end else begin
            exp_s = evq[k].val;
          end
          evq.delete(k);
        end
      end
      if (exp_v || rvalid[d]) begin
        check_val($sformatf("d%0d rvalid", d), rvalid[d], exp_v);
        if (exp_v) check_val($sformatf("d%0d rdata", d), rdata[d], exp_d);
      end
      if (exp_s != 32'h0 || strb[d] != 32'h0) begin
        check_val($sformatf("d%0d strobe", d), strb[d], exp_s);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_idle(input int d);
    @(posedge clk);
    #1;
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  // Drives one request and holds it until accepted; the wait count must equal
  // the instance's wait-state setting.
  task automatic do_access(input int d, input logic [7:0] a, input bit r, input bit w,
                           input logic [7:0] wd, input logic [255:0] st);
    int waits;
    bit tmo;
    waits = 0;
    tmo   = 1'b0;
    @(posedge clk);
    #1;
    check_cfg(d);
    addr[d]  = a;
    rd[d]    = r;
    wr[d]    = w;
    wdata[d] = wd;
    stat[d]  = st;
    forever begin
      @(negedge clk);
      if (!wreq[d]) break;
      if (waits == 8) begin
        check_val($sformatf("d%0d accept timeout", d), 1'b0, 1'b1);
        tmo = 1'b1;
        break;
      end
      waits++;
      @(posedge clk);
      #1;
    end
    if (!tmo) begin
      check_val($sformatf("d%0d waits", d), waits, WS_OF[d]);
      model_accept(d, a, r, w, wd, st);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd    = '0;
    wr    = '0;
    clear_model();
    repeat (n) begin
      @(negedge clk);
      check_val("wreq in reset", wreq, 3'b111);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  function automatic logic [255:0] rand_stat();
    logic [255:0] s;
    for (int k = 0; k < 8; k++) s[32*k +: 32] = $urandom();
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] st;
    logic [7:0]   a;
    logic [7:0]   err_before;
    int           pick;
    int           op;

    reset = 1'b1;
    rd    = '0;
    wr    = '0;
    addr  = '0;
    wdata = '0;
    stat  = '0;
    clear_model();

    // Reset and idle
    do_reset(3);
    repeat (5) begin
      @(negedge clk);
      check_val("wreq idle", wreq, 3'b000);
      check_val("rvalid idle", rvalid, 3'b000);
    end
    for (int d = 0; d < 3; d++) check_cfg(d);
    do_access(0, 8'hFF, 1'b1, 1'b0, 8'h00, '0);
    bus_idle(0);

    // Single write then read-back, one wait state
    do_access(0, 8'h03, 1'b0, 1'b1, 8'hA5, '0);
    do_access(0, 8'h03, 1'b1, 1'b0, 8'h00, '0);
    bus_idle(0);
    idle(4);
    @(negedge clk);
    check_val("d0 cfg byte3", cfg[0][31:24], 8'hA5);

    // Back-to-back status reads, zero wait states
    st = '0;
    st[7:0]   = 8'h11;
    st[15:8]  = 8'h22;
    st[23:16] = 8'h33;
    do_access(1, 8'h80, 1'b1, 1'b0, 8'h00, st);
    do_access(1, 8'h81, 1'b1, 1'b0, 8'h00, st);
    do_access(1, 8'h82, 1'b1, 1'b0, 8'h00, st);
    bus_idle(1);
    idle(6);

    // err_cnt: four distinct error causes, clear, saturation
    do_access(0, 8'h80, 1'b0, 1'b1, 8'h01, '0);
    do_access(0, 8'h40, 1'b0, 1'b1, 8'h02, '0);
    do_access(0, 8'h40, 1'b1, 1'b0, 8'h00, '0);
    do_access(0, 8'h03, 1'b1, 1'b1, 8'h5C, '0);
    do_access(0, 8'hFF, 1'b1, 1'b0, 8'h00, '0);
    bus_idle(0);
    idle(4);
    check_val("d0 err after four", merr[0] == 8'h04, 1'b1);
    do_access(0, 8'hFF, 1'b0, 1'b1, 8'h12, '0);
    do_access(0, 8'hFF, 1'b1, 1'b0, 8'h00, '0);
    repeat (300) do_access(0, 8'h90, 1'b0, 1'b1, 8'($urandom()), '0);
    do_access(0, 8'hFF, 1'b1, 1'b0, 8'h00, '0);
    bus_idle(0);
    idle(4);

    // Read accepted, reset one cycle later: the response must never appear
    do_access(0, 8'h03, 1'b1, 1'b0, 8'h00, '0);
    do_reset(2);
    idle(6);

    // Write waiting through a reset: wait count restarts, register untouched
    @(posedge clk);
    #1;
    addr[0]  = 8'h05;
    wdata[0] = 8'h77;
    wr[0]    = 1'b1;
    @(negedge clk);
    check_val("d0 wait before reset", wreq[0], 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    check_val("d0 wait during reset", wreq[0], 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("d0 wait restarted", wreq[0], 1'b1);
    @(posedge clk);
    #1;
    wr[0] = 1'b0;
    idle(2);
    @(negedge clk);
    check_val("d0 reg5 untouched", cfg[0][47:40], 8'h00);

    // Request dropped mid-wait with three wait states
    do_access(2, 8'h07, 1'b0, 1'b1, 8'h99, '0);
    bus_idle(2);
    err_before = merr[2];
    @(posedge clk);
    #1;
    addr[2]  = 8'h07;
    wdata[2] = 8'h5A;
    wr[2]    = 1'b1;
    @(negedge clk);
    check_val("d2 drop wait1", wreq[2], 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("d2 drop wait2", wreq[2], 1'b1);
    @(posedge clk);
    #1;
    wr[2] = 1'b0;
    @(negedge clk);
    check_val("d2 reg7 after drop", cfg[2][63:56], 8'h99);
    do_access(2, 8'hFF, 1'b1, 1'b0, 8'h00, '0);
    check_val("d2 err unchanged", merr[2] == err_before, 1'b1);
    do_access(2, 8'h07, 1'b0, 1'b1, 8'h3C, '0);
    bus_idle(2);
    idle(6);

    // Randomized traffic on every instance
    for (int d = 0; d < 3; d++) begin
      repeat (150) begin
        pick = $urandom_range(0, 9);
        if (pick <= 4)      a = 8'($urandom_range(0, 31));
        else if (pick <= 6) a = 8'($urandom_range(128, 159));
        else if (pick == 7) a = 8'hFF;
        else begin
          a = 8'($urandom_range(32, 254));
          while (a >= 8'h80 && a < 8'hA0) a = 8'($urandom_range(32, 254));
        end
        op = $urandom_range(0, 15);
        if (op == 0)     do_access(d, a, 1'b1, 1'b1, 8'($urandom()), rand_stat());
        else if (op < 8) do_access(d, a, 1'b1, 1'b0, 8'h00, rand_stat());
        else             do_access(d, a, 1'b0, 1'b1, 8'($urandom()), rand_stat());
        if ($urandom_range(0, 3) == 0) bus_idle(d);
      end
      do_access(d, 8'hFF, 1'b1, 1'b0, 8'h00, '0);
      bus_idle(d);
      idle(8);
      check_cfg(d);
    end

    idle(4);
    check_val("pending responses", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
